// File: rtl/synth_cfg_pkg.sv
// Shared types for the synth configuration-register write path.
// Used by the write scheduler and by the sweep engine.
package synth_cfg_pkg;

  localparam int CFG_WORDS     = 8;
  localparam int CFG_ADDR_BITS = 3;

  typedef enum logic {
    LANE_LO = 1'b0,
    LANE_HI = 1'b1
  } cfg_lane_e;

  typedef struct packed {
    logic [1:0]               we;
    logic [CFG_ADDR_BITS-1:0] addr;
    logic [15:0]              data;
  } cfg_write_t;

  function automatic logic [1:0] lane_we(input cfg_lane_e lane);
    return (lane == LANE_HI) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cfg_byte_fifo.sv
// Registered FIFO for host byte writes; head is always presented, pop/push same cycle allowed.
// Push is ignored when full, pop when empty; flush empties it and drops a same-cycle push.
module cfg_byte_fifo #(
  parameter int W          = 12,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [W-1:0]        push_dat,
  input  logic                pop,
  input  logic                flush,
  output logic [W-1:0]        head_dat,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/cfg_write_scheduler.sv
// Arbitrates the cfg write port: sweep overrides win, queued host bytes retire on free cycles.
// Host bytes issue one cycle after push at the earliest; host_ready drops when the queue is full.
module cfg_write_scheduler
  import synth_cfg_pkg::*;
#(
  parameter int ADDR_BITS  = CFG_ADDR_BITS,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_valid,
  output logic                 host_ready,
  input  logic [ADDR_BITS-1:0] host_addr,
  input  logic                 host_hi,
  input  logic [7:0]           host_data,
  input  logic                 flush,
  input  logic                 ovr_we,
  input  logic [ADDR_BITS-1:0] ovr_addr,
  input  logic [15:0]          ovr_data,
  output logic [1:0]           cfg_we,
  output logic [ADDR_BITS-1:0] cfg_w_addr,
  output logic [15:0]          cfg_w_data,
  output logic [DEPTH_LOG2:0]  pending,
  output logic                 overflow
);

  localparam int ENTRY_W = ADDR_BITS + 9;

  logic [ENTRY_W-1:0]   head_dat;
  logic [ADDR_BITS-1:0] head_addr;
  logic                 head_hi;
  logic [7:0]           head_data;
  logic                 fifo_full, fifo_empty;
  logic                 host_push, host_pop;
  logic                 overflow_q, overflow_d;
  cfg_write_t           wr;

  assign {head_addr, head_hi, head_data} = head_dat;

  cfg_byte_fifo #(
    .W          (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (host_push),
    .push_dat ({host_addr, host_hi, host_data}),
    .pop      (host_pop),
    .flush    (flush),
    .head_dat (head_dat),
    .count    (pending),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    host_ready = !reset && !fifo_full;
    host_push  = host_valid && host_ready;
    host_pop   = 1'b0;
    // Idle cycles still present the head fields so the write bus stays stable.
    wr.we      = 2'b00;
    wr.addr    = CFG_ADDR_BITS'(head_addr);
    wr.data    = {head_data, head_data};
    if (!reset) begin
      if (ovr_we) begin
        wr.we   = 2'b11;
        wr.addr = CFG_ADDR_BITS'(ovr_addr);
        wr.data = ovr_data;
      end else if (!fifo_empty && !flush) begin
        wr.we    = lane_we(cfg_lane_e'(head_hi));
        host_pop = 1'b1;
      end
    end
    overflow_d = overflow_q || (host_valid && !host_ready);
  end

  assign cfg_we     = wr.we;
  assign cfg_w_addr = ADDR_BITS'(wr.addr);
  assign cfg_w_data = wr.data;
  assign overflow   = overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

endmodule
